// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Write-back arbiter for the single write port of the register file, plus the
// per-register busy scoreboard that the issue stage uses to detect RAW/WAW
// hazards. Two requesters (ALU = A, LSU = B) share the port with round-robin
// fairness. The winning request is registered once before it reaches the
// register file.
module rf_wb_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_COUNT  = 32
) (
    input  logic                  i_CLK,
    input  logic                  i_RSTn,
    input  logic                  i_a_valid,
    input  logic [ADDR_WIDTH-1:0] i_a_addr,
    input  logic [DATA_WIDTH-1:0] i_a_data,
    output logic                  o_a_ready,
    input  logic                  i_b_valid,
    input  logic [ADDR_WIDTH-1:0] i_b_addr,
    input  logic [DATA_WIDTH-1:0] i_b_data,
    output logic                  o_b_ready,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    input  logic                  i_claim_valid,
    input  logic [ADDR_WIDTH-1:0] i_claim_addr,
    input  logic [ADDR_WIDTH-1:0] i_chk0_addr,
    input  logic [ADDR_WIDTH-1:0] i_chk1_addr,
    output logic                  o_stall,
    output logic [REG_COUNT-1:0]  o_busy
);

    // One-hot decode of a register index. Index 0 and indices beyond the
    // register file map to an all-zero mask, so they can never be busy,
    // never be set and never be cleared.
    function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [ADDR_WIDTH-1:0] addr);
        logic [REG_COUNT-1:0] mask;
        mask = '0;
        for (int i = 1; i < REG_COUNT; i++) begin
            if (int'(addr) == i) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

    logic                  a_pref_q;     // 1: A wins when both request
    logic                  a_grant;
    logic                  b_grant;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;
    logic [ADDR_WIDTH-1:0] wr_addr_p1;
    logic [DATA_WIDTH-1:0] wr_data_p1;
    logic [REG_COUNT-1:0]  busy_q;
    logic [REG_COUNT-1:0]  busy_d;
    logic [REG_COUNT-1:0]  clr_mask;
    logic [REG_COUNT-1:0]  set_mask;
    logic [REG_COUNT-1:0]  chk_mask;
    logic                  stall;

    // Grant selection: a lone requester always wins; a tie goes to whoever
    // did not win last. Only the valids and the pointer feed the grant.
    always_comb begin
        a_grant  = i_a_valid && (!i_b_valid || a_pref_q);
        b_grant  = i_b_valid && (!i_a_valid || !a_pref_q);
        win_addr = b_grant ? i_b_addr : i_a_addr;
        win_data = b_grant ? i_b_data : i_a_data;
    end

    // Round-robin pointer: records the winner of each grant, holds otherwise.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            a_pref_q <= 1'b1;
        end else if (a_grant) begin
            a_pref_q <= 1'b0;
        end else if (b_grant) begin
            a_pref_q <= 1'b1;
        end
    end

    // Write-port stage: the granted request is presented to the register file
    // one cycle later. Writes to index 0 or out of range are accepted but
    // dropped by presenting address 0; data simply holds when idle.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
        end else if (a_grant || b_grant) begin
            wr_addr_p1 <= (|reg_onehot(win_addr)) ? win_addr : '0;
            wr_data_p1 <= win_data;
        end else begin
            wr_addr_p1 <= '0;
        end
    end

    // Hazard check and scoreboard next state. The presented write clears its
    // bit (the register file commits on this edge); an accepted claim sets its
    // bit and takes priority over a same-edge clear.
    always_comb begin
        chk_mask  = reg_onehot(i_chk0_addr) | reg_onehot(i_chk1_addr) | reg_onehot(i_claim_addr);
        stall     = i_claim_valid && (|(busy_q & chk_mask));
        clr_mask  = reg_onehot(wr_addr_p1);
        set_mask  = (i_claim_valid && !stall) ? reg_onehot(i_claim_addr) : '0;
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign o_a_ready = a_grant;
    assign o_b_ready = b_grant;
    assign o_wr_addr = wr_addr_p1;
    assign o_wr_data = wr_data_p1;
    assign o_stall   = stall;
    assign o_busy    = busy_q;

endmodule
